// File: rtl/mux_chip_pkg.sv
// Shared constants for the 2:1 selector chip: select encodings and
// default widths used by the interface, the top and the toggle counter.
package mux_chip_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : mux_chip_pkg

// File: rtl/mux_chip_if.sv
// Signal bundle for the 2:1 selector chip.
// Optional MUX_CHIP_PARITY_EN adds the registered parity output par_q.
interface mux_chip_if
  import mux_chip_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             s_q;
  logic [CNT_W-1:0] tog_cnt;
`ifdef MUX_CHIP_PARITY_EN
  logic             par_q;

  modport master (output a, b, s, en, input out, out_q, s_q, tog_cnt, par_q);
  modport slave  (input a, b, s, en, output out, out_q, s_q, tog_cnt, par_q);
`else
  modport master (output a, b, s, en, input out, out_q, s_q, tog_cnt);
  modport slave  (input a, b, s, en, output out, out_q, s_q, tog_cnt);
`endif

endinterface : mux_chip_if

// File: rtl/mux_chip_toggle_cnt.sv
// Counts changes of the select line on rising clock edges. Keeps its own
// previous-select flop (independent of the load enable) and saturates at
// all-ones instead of wrapping.
module mux_chip_toggle_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_s,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_prev_s;
  logic [CNT_W-1:0] r_cnt;
  logic             w_toggle;
  logic             w_sat;

  assign w_toggle = (i_s != r_prev_s);
  assign w_sat    = &r_cnt;

  // Previous-select history and saturating toggle count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_s <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_prev_s <= i_s;
      if (w_toggle && !w_sat) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule : mux_chip_toggle_cnt

// File: rtl/mux_chip_2to1.sv
// 2:1 selector chip: combinational mux, enable-gated registered copy of the
// mux result and of the select, plus a saturating select-toggle counter.
// Optional MUX_CHIP_PARITY_EN adds par_q = XOR-reduction of out_q.
module mux_chip_2to1
  import mux_chip_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic       clk,
  input logic       rst,
  mux_chip_if.slave bus
);

  logic [WIDTH-1:0] w_mux;
  logic [WIDTH-1:0] r_out_q;
  logic             r_s_q;
  logic [CNT_W-1:0] w_tog_cnt;

  // Combinational select; an unknown select yields an unknown result.
  always_comb begin
    w_mux = '0;
    case (bus.s)
      SEL_A:   w_mux = bus.a;
      SEL_B:   w_mux = bus.b;
      default: w_mux = {WIDTH{1'bx}};
    endcase
  end

  // Registered mux result and select, loaded only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_q <= '0;
      r_s_q   <= 1'b0;
    end else if (bus.en) begin
      r_out_q <= w_mux;
      r_s_q   <= bus.s;
    end
  end

  mux_chip_toggle_cnt #(
    .CNT_W (CNT_W)
  ) u_toggle_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_s   (bus.s),
    .o_cnt (w_tog_cnt)
  );

`ifdef MUX_CHIP_PARITY_EN
  logic r_par_q;

  function automatic logic f_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Parity tracks the value being loaded into out_q, so both change together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_q <= 1'b0;
    end else if (bus.en) begin
      r_par_q <= f_parity(w_mux);
    end
  end

  assign bus.par_q = r_par_q;
`endif

  assign bus.out     = w_mux;
  assign bus.out_q   = r_out_q;
  assign bus.s_q     = r_s_q;
  assign bus.tog_cnt = w_tog_cnt;

endmodule : mux_chip_2to1

// File: tb/tb_mux_chip_2to1.sv
// Scoreboard bench for mux_chip_2to1: a WIDTH=8/CNT_W=16 instance for the
// datapath and reset checks, a WIDTH=1/CNT_W=2 instance for the truth table
// and counter saturation. Stimulus pushes expectations; a monitor compares.
module tb_mux_chip_2to1;

  localparam int K_OUT8  = 0;
  localparam int K_OUTQ8 = 1;
  localparam int K_SQ8   = 2;
  localparam int K_TOG8  = 3;
  localparam int K_OUT1  = 4;
  localparam int K_TOG1  = 5;
  localparam int K_PAR8  = 6;

  typedef struct {
    string       name;
    int          kind;
    logic [15:0] exp;
  } sb_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  sb_t  sb[$];
  event ev_sample;

  mux_chip_if #(.WIDTH(8), .CNT_W(16)) if8 ();
  mux_chip_if #(.WIDTH(1), .CNT_W(2))  if1 ();

  mux_chip_2to1 #(.WIDTH(8), .CNT_W(16)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  mux_chip_2to1 #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] actual_of(input int kind);
    logic [15:0] v;
    v = 16'h0000;
    case (kind)
      K_OUT8:  v = {8'h00, if8.out};
      K_OUTQ8: v = {8'h00, if8.out_q};
      K_SQ8:   v = {15'h0000, if8.s_q};
      K_TOG8:  v = if8.tog_cnt;
      K_OUT1:  v = {15'h0000, if1.out};
      K_TOG1:  v = {14'h0000, if1.tog_cnt};
`ifdef MUX_CHIP_PARITY_EN
      K_PAR8:  v = {15'h0000, if8.par_q};
`endif
      default: v = 16'hDEAD;
    endcase
    return v;
  endfunction

  // Monitor: on each sample point, drain the scoreboard and compare.
  initial begin
    sb_t         e;
    logic [15:0] act;
    forever begin
      @(ev_sample);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = actual_of(e.kind);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s got %h expected %h at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  task automatic push(input string n, input int k, input logic [15:0] v);
    sb_t e;
    e.name = n;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic sample();
    -> ev_sample;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] tt_vec [8];
  logic       tt_exp [8];
  logic [1:0] sat_exp [5];
  logic [7:0] hold_a [3];
  logic [7:0] hold_b [3];
  logic       hold_s [3];

  initial begin
    checks = 0;
    errors = 0;
    // (a,b,s) vectors and hand-computed outputs
    tt_vec[0] = 3'b000; tt_exp[0] = 1'b0;
    tt_vec[1] = 3'b100; tt_exp[1] = 1'b1;
    tt_vec[2] = 3'b010; tt_exp[2] = 1'b0;
    tt_vec[3] = 3'b110; tt_exp[3] = 1'b1;
    tt_vec[4] = 3'b001; tt_exp[4] = 1'b0;
    tt_vec[5] = 3'b101; tt_exp[5] = 1'b0;
    tt_vec[6] = 3'b011; tt_exp[6] = 1'b1;
    tt_vec[7] = 3'b111; tt_exp[7] = 1'b1;
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    hold_a[0] = 8'h11; hold_b[0] = 8'h22; hold_s[0] = 1'b1;
    hold_a[1] = 8'h44; hold_b[1] = 8'h55; hold_s[1] = 1'b0;
    hold_a[2] = 8'h66; hold_b[2] = 8'h77; hold_s[2] = 1'b1;

    rst    = 1'b1;
    if8.a  = 8'h00; if8.b = 8'h00; if8.s = 1'b0; if8.en = 1'b0;
    if1.a  = 1'b0;  if1.b = 1'b0;  if1.s = 1'b0; if1.en = 1'b0;

    // Reset state
    #2;
    push("rst_out_q", K_OUTQ8, 16'h0000);
    push("rst_s_q",   K_SQ8,   16'h0000);
    push("rst_tog8",  K_TOG8,  16'h0000);
    push("rst_tog1",  K_TOG1,  16'h0000);
    sample();
    @(negedge clk);
    rst = 1'b0;

    // Combinational truth table, 10 time units per step
    for (int i = 0; i < 8; i++) begin
      if1.a = tt_vec[i][2];
      if1.b = tt_vec[i][1];
      if1.s = tt_vec[i][0];
      #1;
      push($sformatf("tt_%0d", i), K_OUT1, {15'h0000, tt_exp[i]});
      sample();
      #8;
    end

    // Registered path
    tick();
    if1.s  = 1'b0;
    if8.en = 1'b1; if8.a = 8'h3C; if8.b = 8'hA5; if8.s = 1'b1;
    #1;
    push("reg_out_comb", K_OUT8, 16'h00A5);
    sample();
    tick();
    push("reg_out_q_b", K_OUTQ8, 16'h00A5);
    push("reg_s_q_1",   K_SQ8,   16'h0001);
    sample();
    if8.s = 1'b0;
    tick();
    push("reg_out_q_a", K_OUTQ8, 16'h003C);
    push("reg_s_q_0",   K_SQ8,   16'h0000);
    push("reg_tog_2",   K_TOG8,  16'h0002);
    sample();

    // Hold with en=0 while inputs and select move
    if8.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if8.a = hold_a[i]; if8.b = hold_b[i]; if8.s = hold_s[i];
      #1;
      push($sformatf("hold_out_%0d", i), K_OUT8,
           {8'h00, (hold_s[i] ? hold_b[i] : hold_a[i])});
      sample();
      tick();
      push($sformatf("hold_out_q_%0d", i), K_OUTQ8, 16'h003C);
      push($sformatf("hold_s_q_%0d", i),   K_SQ8,   16'h0000);
      push($sformatf("hold_tog_%0d", i),   K_TOG8,  16'(3 + i));
      sample();
    end

    // Load A5 with no select change, then async reset between edges
    if8.en = 1'b1; if8.a = 8'h3C; if8.b = 8'hA5; if8.s = 1'b1;
    tick();
    push("pre_rst_out_q", K_OUTQ8, 16'h00A5);
    push("pre_rst_tog",   K_TOG8,  16'h0005);
    sample();
    #2;
    rst = 1'b1;
    #1;
    push("arst_out_q", K_OUTQ8, 16'h0000);
    push("arst_s_q",   K_SQ8,   16'h0000);
    push("arst_tog8",  K_TOG8,  16'h0000);
    push("arst_out",   K_OUT8,  16'h00A5);
    sample();
    rst = 1'b0;

    // First s=1 sample after reset is one toggle
    tick();
    push("post_rst_tog8",  K_TOG8,  16'h0001);
    push("post_rst_out_q", K_OUTQ8, 16'h00A5);
    push("post_rst_s_q",   K_SQ8,   16'h0001);
    push("post_rst_tog1",  K_TOG1,  16'h0000);
    sample();

    // Counter saturation on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      if1.s = ~if1.s;
      tick();
      push($sformatf("sat_%0d", i), K_TOG1, {14'h0000, sat_exp[i]});
      sample();
    end

    // Parity path (out_q checked in every build)
    if8.en = 1'b1; if8.s = 1'b0; if8.a = 8'h07;
    tick();
    push("par_out_q_07", K_OUTQ8, 16'h0007);
`ifdef MUX_CHIP_PARITY_EN
    push("par_07", K_PAR8, 16'h0001);
`endif
    sample();
    if8.a = 8'h03;
    tick();
    push("par_out_q_03", K_OUTQ8, 16'h0003);
`ifdef MUX_CHIP_PARITY_EN
    push("par_03", K_PAR8, 16'h0000);
`endif
    sample();

    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_chip_2to1
